// File: rtl/ped_request_conditioner.sv
// -----------------------------------------------------------------------------
// ped_request_conditioner
//
// Front end for the pedestrian push-button. The raw button is synchronised,
// debounced and edge-detected. Each accepted press latches a single pending
// crossing request. The request is held until the traffic controller
// acknowledges it. Presses made while a request is pending, or while the walk
// phase that answers it is running, are dropped. As a result the controller
// sees at most one request per walk cycle.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to move btn_level (>= 2)
//   COUNT_W         : width of the saturating accepted-request counter
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset, clears every register
//   btn_in      in   raw button, asynchronous to clk, active-high
//   walk_active in   high while the pedestrian light is on
//   req_ack     in   one-cycle pulse accepting the pending request
//   btn_level   out  debounced button level
//   press_pulse out  one-cycle pulse per debounced rising edge
//   ped_req     out  pending crossing request, held until acknowledged
//   press_count out  number of accepted requests, saturating
//   state_dbg   out  current FSM state (00 idle, 01 pending, 10 serving)
// -----------------------------------------------------------------------------
module ped_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_250_000,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_in,
    input  logic               walk_active,
    input  logic               req_ack,
    output logic               btn_level,
    output logic               press_pulse,
    output logic               ped_req,
    output logic [COUNT_W-1:0] press_count,
    output logic [1:0]         state_dbg
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_SERVING = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    logic               sync1_q;
    logic               sync2_q;
    logic               btn_s;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               level_q;
    logic               level_d;
    logic               level_prev_q;
    logic               press_q;
    logic               press_d;
    state_e             state_q;
    state_e             state_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               seen_walk_q;
    logic               seen_walk_d;
    logic               ped_req_q;

    assign btn_s = sync2_q;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive samples that disagree with the current level
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (btn_s == level_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            // This is the last disagreeing sample of the run, so adopt the new level
            level_d = btn_s;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pulse when the level rose on the previous edge; a falling edge gives nothing
    always_comb begin
        press_d = level_q & ~level_prev_q;
    end

    // Request FSM next-state, counter and walk-seen tracking
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        seen_walk_d = seen_walk_q;
        case (state_q)
            ST_IDLE: begin
                if (press_q && !walk_active) begin
                    state_d = ST_PENDING;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + COUNT_W'(1);
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // An ack that coincides with a press wins; the press is simply not looked at
                if (req_ack) begin
                    state_d     = ST_SERVING;
                    seen_walk_d = 1'b0;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_SERVING: begin
                // Leave only once the walk phase has been seen and has ended
                if (seen_walk_q && !walk_active) begin
                    state_d = ST_IDLE;
                end else if (walk_active) begin
                    state_d     = ST_SERVING;
                    seen_walk_d = 1'b1;
                end else begin
                    state_d = ST_SERVING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Debounce, edge-detect and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= {CNT_W{1'b0}};
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            state_q      <= ST_IDLE;
            count_q      <= {COUNT_W{1'b0}};
            seen_walk_q  <= 1'b0;
            ped_req_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            state_q      <= state_d;
            count_q      <= count_d;
            seen_walk_q  <= seen_walk_d;
            ped_req_q    <= (state_d == ST_PENDING);
        end
    end

    assign btn_level   = level_q;
    assign press_pulse = press_q;
    assign ped_req     = ped_req_q;
    assign press_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for ped_request_conditioner (DEBOUNCE_CYCLES=4, COUNT_W=2).
// A cycle-level behavioural model derived from the button/request rules runs
// alongside the DUT. A negedge process compares every output each cycle.
// Directed checks with literal expectations pin the key timings.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ped_request_conditioner;

    localparam int D     = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn_in;
    logic          walk_active;
    logic          req_ack;
    logic          btn_level;
    logic          press_pulse;
    logic          ped_req;
    logic [CW-1:0] press_count;
    logic [1:0]    state_dbg;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // model state
    bit m_d1, m_d2;       // button samples from one and two edges ago
    int m_run;            // consecutive samples disagreeing with the level
    bit m_level;
    bit m_rose;           // level rose at the latest edge
    bit m_pulse;
    int m_state;          // 0 idle, 1 pending, 2 serving
    bit m_seen;
    int m_count;

    ped_request_conditioner #(.DEBOUNCE_CYCLES(D), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .walk_active(walk_active),
        .req_ack(req_ack), .btn_level(btn_level), .press_pulse(press_pulse),
        .ped_req(ped_req), .press_count(press_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_run = 0; m_level = 0; m_rose = 0;
        m_pulse = 0; m_state = 0; m_seen = 0; m_count = 0;
    endtask

    // One rising edge of the model, given the inputs present before the edge
    task automatic model_step(input bit b, input bit w, input bit a);
        bit s;
        bit pulse_in;
        bit rose_now;
        pulse_in = m_pulse;
        s    = m_d2;
        m_d2 = m_d1;
        m_d1 = b;
        rose_now = 0;
        if (s != m_level) begin
            m_run++;
            if (m_run == D) begin
                rose_now = s;
                m_level  = s;
                m_run    = 0;
            end
        end else begin
            m_run = 0;
        end
        if (m_state == 0) begin
            if (pulse_in && !w) begin
                m_state = 1;
                m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
            end
        end else if (m_state == 1) begin
            if (a) begin
                m_state = 2;
                m_seen  = 0;
            end
        end else begin
            if (m_seen && !w) m_state = 0;
            else if (w) m_seen = 1;
        end
        m_pulse = m_rose;
        m_rose  = rose_now;
    endtask

    task automatic tick();
        bit b, w, a;
        b = btn_in; w = walk_active; a = req_ack;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(b, w, a);
        #1;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("btn_level",   int'(btn_level),   int'(m_level));
            chk("press_pulse", int'(press_pulse), int'(m_pulse));
            chk("ped_req",     int'(ped_req),     int'(m_state == 1));
            chk("press_count", int'(press_count), m_count);
            chk("state_dbg",   int'(state_dbg),   m_state);
        end
    end

    task automatic press();
        btn_in = 1'b1;
        repeat (8) tick();
        btn_in = 1'b0;
        repeat (8) tick();
    endtask

    task automatic ack_pulse();
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
    endtask

    task automatic walk_cycle();
        walk_active = 1'b1;
        repeat (10) tick();
        walk_active = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bit any_pulse;
        rst_n = 1'b0; btn_in = 1'b1; walk_active = 1'b0; req_ack = 1'b0;
        model_reset();
        chk_on = 1'b1;

        // reset with button held, then latency to level/pulse/request
        repeat (3) tick();
        chk("rst_level", int'(btn_level), 0);
        chk("rst_state", int'(state_dbg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) chk("lvl_at5", int'(btn_level), 0);
            if (k == 6) begin
                chk("lvl_at6", int'(btn_level), 1);
                chk("model_lvl_at6", int'(m_level), 1);
                chk("pulse_at6", int'(press_pulse), 0);
            end
            if (k == 7) begin
                chk("pulse_at7", int'(press_pulse), 1);
                chk("req_at7", int'(ped_req), 0);
            end
            if (k == 8) begin
                chk("req_at8", int'(ped_req), 1);
                chk("count_at8", int'(press_count), 1);
                chk("state_at8", int'(state_dbg), 1);
            end
        end

        // handshake and walk phase
        btn_in = 1'b0;
        repeat (8) tick();
        ack_pulse();
        chk("req_after_ack", int'(ped_req), 0);
        chk("serving", int'(state_dbg), 2);
        walk_active = 1'b1;
        repeat (10) tick();
        walk_active = 1'b0;
        chk("still_serving", int'(state_dbg), 2);
        tick();
        chk("back_idle", int'(state_dbg), 0);

        // bounce rejection
        any_pulse = 0;
        repeat (5) begin
            btn_in = 1'b1;
            repeat (3) begin tick(); any_pulse |= press_pulse; end
            btn_in = 1'b0;
            repeat (2) begin tick(); any_pulse |= press_pulse; end
        end
        repeat (10) begin tick(); any_pulse |= press_pulse; end
        chk("bounce_level", int'(btn_level), 0);
        chk("bounce_pulse", int'(any_pulse), 0);
        chk("bounce_count", int'(press_count), 1);

        // discard rules
        walk_active = 1'b1;
        press();
        walk_active = 1'b0;
        chk("walk_press_state", int'(state_dbg), 0);
        chk("walk_press_count", int'(press_count), 1);
        press();
        chk("accept_state", int'(state_dbg), 1);
        chk("accept_count", int'(press_count), 2);
        press();
        chk("pending_press_count", int'(press_count), 2);
        ack_pulse();
        press();
        chk("serving_press_state", int'(state_dbg), 2);
        chk("serving_press_count", int'(press_count), 2);
        walk_cycle();
        chk("discard_idle", int'(state_dbg), 0);

        // press pulse coincident with ack
        press();
        chk("third_count", int'(press_count), 3);
        btn_in = 1'b1;
        repeat (7) tick();
        chk("coinc_pulse", int'(press_pulse), 1);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        chk("coinc_state", int'(state_dbg), 2);
        chk("coinc_req", int'(ped_req), 0);
        chk("coinc_count", int'(press_count), 3);
        btn_in = 1'b0;
        repeat (8) tick();
        walk_cycle();

        // saturation: two more full request cycles (five accepted in total)
        repeat (2) begin
            press();
            ack_pulse();
            walk_cycle();
        end
        chk("sat_count", int'(press_count), 3);

        // asynchronous reset while pending
        press();
        chk("pre_reset_req", int'(ped_req), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_req", int'(ped_req), 0);
        chk("async_state", int'(state_dbg), 0);
        chk("async_count", int'(press_count), 0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        chk("post_reset_state", int'(state_dbg), 0);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ped_request_conditioner.md
Name: ped_request_conditioner

Overview:
Front end for the pedestrian push-button that feeds the traffic light controller. It synchronises and debounces the raw button. It then latches one pending crossing request and holds it until the controller acknowledges it. Presses made while a request is pending or a walk phase is running are discarded, so the controller sees at most one request per walk cycle.

Parameters:
DEBOUNCE_CYCLES, 1_250_000, consecutive stable clk cycles required before the debounced level changes (10 ms at 125 MHz); legal range >= 2
COUNT_W, 8, width of the saturating accepted-press counter

Ports:
clk  input  1  system clock, 125 MHz, all logic on rising edge
rst_n  input  1  reset, asynchronous assert, active-low; clears every register
btn_in  input  1  raw pedestrian button, asynchronous to clk, active-high
walk_active  input  1  level from the controller, high while pedestrian light is on
req_ack  input  1  one-cycle pulse from the controller accepting the pending request
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle pulse on each debounced rising edge
ped_req  output  1  pending crossing request, held high until acknowledged
press_count  output  COUNT_W  number of accepted requests, saturating
state_dbg  output  2  current FSM state encoding

Behaviour:
- Reset (rst_n=0, asynchronous): sync flops=0, debounce counter=0, btn_level=0, press_pulse=0, ped_req=0, press_count=0, state=IDLE (state_dbg=2'b00), seen_walk=0.
- Synchroniser: two flops; btn_s = btn_in delayed 2 cycles.
- Debounce: counter width $clog2(DEBOUNCE_CYCLES).
  - If btn_s == btn_level, the counter resets to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and btn_s still differs, btn_level <= btn_s and the counter <= 0.
  - Result: btn_level toggles after DEBOUNCE_CYCLES consecutive differing samples.
  - A glitch shorter than that never changes btn_level.
- press_pulse: registered; high exactly 1 cycle, the cycle after btn_level goes 0->1. A falling edge gives no pulse.
- Total latency from a clean btn_in rise to press_pulse = 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states: IDLE=00, PENDING=01, SERVING=10. Encoding 11 is illegal and recovers to IDLE on the next cycle.
  - IDLE: press_pulse & ~walk_active -> PENDING; press_count increments unless it is at all-ones. press_pulse while walk_active=1 is ignored. req_ack is ignored.
  - PENDING: ped_req=1. req_ack -> SERVING and seen_walk <= 0. Further presses are ignored. If press_pulse and req_ack arrive together, the ack wins and the press is discarded.
  - SERVING: ped_req=0, presses are ignored. seen_walk <= 1 when walk_active=1. Exit to IDLE on the first cycle with seen_walk=1 and walk_active=0, i.e. after the walk phase ends.
- ped_req is decoded from the registered state: it rises 1 cycle after press_pulse and falls 1 cycle after req_ack.
- press_count saturates at 2^COUNT_W-1 and never wraps.
- Reset mid-operation (any state, counter mid-count) returns immediately to the reset values above. No request survives reset.

Test Plan:
- Reset/defaults (DEBOUNCE_CYCLES=4): hold rst_n=0 with btn_in=1 -> all outputs 0; release -> btn_level rises 6 cycles after release, press_pulse 1 cycle later, ped_req 1 cycle after that.
- Bounce rejection: btn_in high for 3 cycles, low for 2, repeated 5 times -> btn_level stays 0, no press_pulse, press_count=0.
- Request handshake: clean press with walk_active=0 -> ped_req=1 and press_count=1. Pulse req_ack -> ped_req=0 next cycle, state=SERVING. walk_active high 10 cycles then low -> state=IDLE one cycle later.
- Discard rules: second press while PENDING, press during SERVING, and press in IDLE with walk_active=1 -> each gives press_pulse but no state change, press_count unchanged.
- Simultaneous: press_pulse coincident with req_ack in PENDING -> SERVING, ped_req=0, press_count unchanged. Saturation with COUNT_W=2: 5 full request cycles -> press_count=3.
- Async reset mid-PENDING: drop rst_n between clock edges -> ped_req=0 and state_dbg=00 before the next clk edge.
